// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: fetch PC, combinational imem request, prefetch FIFO
// of {pc, instr} pairs to decode, redirect handling and fetch fault detection.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC      = 64'h0,
  parameter int unsigned FIFO_DEPTH    = 2,
  parameter logic [63:0] MEM_LAST_BYTE = 64'd300
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  input  logic        if_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        fetch_fault
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_RUN,
    ST_FAULT
  } state_t;

  state_t             state, state_next;
  logic [63:0]        fpc, fpc_next;
  logic [CNT_W-1:0]   count, count_next;
  logic [PTR_W-1:0]   rd_ptr, rd_next;
  logic [PTR_W-1:0]   wr_ptr, wr_next;
  logic [63:0]        pc_mem    [FIFO_DEPTH];
  logic [31:0]        instr_mem [FIFO_DEPTH];

  logic               legal;
  logic               push;
  logic               pop;
  logic               head_valid_next;
  logic [63:0]        head_pc_next;
  logic [31:0]        head_instr_next;
  logic               fault_next;

  assign imem_addr = fpc;

  // Legal fetch: word aligned and the whole word lies inside instruction memory.
  assign legal = (fpc[1:0] == 2'b00) &&
                 (({1'b0, fpc} + 65'd3) <= {1'b0, MEM_LAST_BYTE});
  assign pop   = if_valid & if_ready & ~redirect_valid;
  assign push  = (state == ST_RUN) & legal & ~redirect_valid &
                 ((count < CNT_W'(FIFO_DEPTH)) | pop);

  // Next-state, pointer and head computation.
  always_comb begin
    state_next      = state;
    fpc_next        = fpc;
    count_next      = count;
    rd_next         = rd_ptr;
    wr_next         = wr_ptr;
    head_valid_next = 1'b0;
    head_pc_next    = 64'h0;
    head_instr_next = 32'h0;

    if (redirect_valid) begin
      fpc_next   = redirect_pc;
      count_next = '0;
      rd_next    = '0;
      wr_next    = '0;
      state_next = (redirect_pc[1:0] != 2'b00) ? ST_FAULT : ST_RUN;
    end else begin
      if (push) begin
        fpc_next = fpc + 64'd4;
        wr_next  = PTR_W'(wr_ptr + 1'b1);
      end
      if (pop) begin
        rd_next = PTR_W'(rd_ptr + 1'b1);
      end
      count_next = count + CNT_W'(push) - CNT_W'(pop);
      if ((state == ST_RUN) && !legal) begin
        state_next = ST_FAULT;
      end
    end

    // The next head may be the entry being written this very cycle.
    if (count_next != '0) begin
      head_valid_next = 1'b1;
      if (push && (rd_next == wr_ptr)) begin
        head_pc_next    = fpc;
        head_instr_next = imem_rdata;
      end else begin
        head_pc_next    = pc_mem[rd_next];
        head_instr_next = instr_mem[rd_next];
      end
    end

    fault_next = (state_next == ST_FAULT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_RUN;
      fpc         <= RESET_PC;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      if_valid    <= 1'b0;
      if_pc       <= 64'h0;
      if_instr    <= 32'h0;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_next;
      fpc         <= fpc_next;
      count       <= count_next;
      rd_ptr      <= rd_next;
      wr_ptr      <= wr_next;
      if_valid    <= head_valid_next;
      if_pc       <= head_pc_next;
      if_instr    <= head_instr_next;
      fetch_fault <= fault_next;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        pc_mem[i]    <= 64'h0;
        instr_mem[i] <= 32'h0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]    <= fpc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Requester side of the instruction memory interface; drives the byte address and consumes the returned 32-bit little-endian word.
- The instruction memory read is combinational: the word at imem_addr is valid in the same cycle.
- Holds the fetch PC and a small prefetch FIFO of {pc, instr} pairs feeding decode with a valid/ready handshake.
- Handles redirects (branch/jump) and flags misaligned or out-of-range fetches.

Parameters:
- RESET_PC, 64'h0, fetch PC loaded on reset.
- FIFO_DEPTH, 2, prefetch entries, power of two, minimum 2.
- MEM_LAST_BYTE, 300, highest valid byte address of instruction memory.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- imem_addr  out  64  byte address to instruction memory; always equals fpc
- imem_rdata  in  32  instruction word at imem_addr, same cycle
- if_valid  out  1  FIFO head valid to decode
- if_instr  out  32  head instruction; 0 when empty
- if_pc  out  64  head PC; 0 when empty
- if_ready  in  1  decode accepts head this cycle
- redirect_valid  in  1  load new fetch PC, flush FIFO
- redirect_pc  in  64  redirect target
- fetch_fault  out  1  fetch halted on misaligned or out-of-range PC

Behaviour:
- Reset (asynchronous, takes effect immediately even mid-cycle):
  - fpc=RESET_PC, count=0, state=RUN.
  - if_valid=0, if_instr=0, if_pc=0, fetch_fault=0.
  - FIFO storage cleared.
- State RUN, fetch legality: legal = fpc[1:0]==0 and fpc+3 <= MEM_LAST_BYTE.
- pop = if_valid & if_ready & ~redirect_valid.
- push = RUN & legal & ~redirect_valid & (count<FIFO_DEPTH | pop).
  - On push: FIFO tail gets {fpc, imem_rdata}; fpc <= fpc+4 (64-bit wrap, unreachable in practice).
- RUN, not redirecting and not legal: no push, fpc holds, next state FAULT.
  - Buffered entries keep draining.
  - fetch_fault=1 from the next cycle.
- Push and pop in the same cycle while full is allowed; count is unchanged.
- Count arithmetic: count_next = count + push - pop. Read and write pointers wrap modulo FIFO_DEPTH.
- Order is strictly FIFO: no drops, no duplicates.
- Redirect (any state) has priority over push and pop:
  - count <= 0 and all entries are discarded, including a head handshaked in the same cycle, which decode must also discard.
  - fpc <= redirect_pc.
  - If redirect_pc[1:0]!=0: state <= FAULT, fetch_fault=1.
  - Otherwise: state <= RUN, fetch_fault=0 (this is the only way out of FAULT besides reset).
  - Timing: redirect in cycle N → push at the end of N+1 → if_valid with if_pc=redirect_pc in cycle N+2.
- State FAULT:
  - No pushes; fpc frozen; imem_addr=fpc.
  - fetch_fault=1; remaining FIFO entries drain normally.
- Latency from reset release: first edge pushes RESET_PC; if_valid=1 on the following cycle. Sustained throughput is 1 instruction/cycle with if_ready=1.
- Outputs are registered FIFO head (if_*) and state (fetch_fault). imem_addr comes directly from the fpc register; no combinational path from inputs to outputs.

Test Plan:
- Memory words at 0,4,8 = 32'h00500093, 32'h00A00113, 32'h002081B3; release reset with if_ready=1 → if_valid rises on cycle 2; (if_pc, if_instr) = (0,00500093), (4,00A00113), (8,002081B3) on consecutive cycles.
- Hold if_ready=0 for 5 cycles after reset → count saturates at 2, imem_addr holds 8, if_pc holds 0. Raise if_ready → PCs 0,4,8,12 in order, no gap after the first.
- FIFO full, if_ready=1, redirect_valid=1 with redirect_pc=0x40 for one cycle → if_valid=0 next cycle; if_pc=0x40 two cycles after the redirect; the same-cycle handshake is not counted.
- redirect_pc=0x42 → fetch_fault=1, if_valid=0, imem_addr=0x42 frozen. Then redirect_pc=0x10 → fetch_fault=0; if_pc=0x10 delivered two cycles later.
- Sequential run from 0x120 → 0x124 and 0x128 delivered (0x128+3=299). fpc=0x12C is illegal: fetch_fault=1, buffered entries still delivered, then if_valid=0.
- Assert reset_n=0 asynchronously between edges with FIFO full → if_valid, if_instr, if_pc and fetch_fault read 0 immediately; imem_addr=RESET_PC.
